// File: rtl/if_id_fetch_stage.sv
//============================================================================
// Module      : if_id_fetch_stage
// Description : Instruction fetch stage with IF/ID pipeline register and a
//               one-entry skid buffer for words acked while decode stalls.
//               Optional macro FETCH_PERF_CNT_EN adds a stall-cycle counter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module if_id_fetch_stage #(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall,
   input  logic            flush,
   input  logic [XLEN-1:0] branch_target,
   output logic            ifid_valid,
   output logic [XLEN-1:0] ifid_instr,
   output logic [XLEN-1:0] ifid_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]     perf_stall_cycles,
`endif
   output logic            fetch_busy
);

   localparam logic [1:0] c_ST_BOOT  = 2'd0;
   localparam logic [1:0] c_ST_FETCH = 2'd1;
   localparam logic [1:0] c_ST_HOLD  = 2'd2;

   localparam logic [XLEN-1:0] c_RESET_PC = RESET_PC[XLEN-1:0];
   localparam logic [XLEN-1:0] c_PC_STEP  = XLEN'(PC_STEP);

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic            r_ifid_valid;
   logic [XLEN-1:0] r_ifid_instr;
   logic [XLEN-1:0] r_ifid_pc_plus4;
   logic [XLEN-1:0] r_skid_instr;
   logic [XLEN-1:0] r_skid_pc_plus4;
   logic [XLEN-1:0] w_pc_next_seq;
   logic            w_accept;

   assign w_pc_next_seq = r_pc + c_PC_STEP;
   // An empty IF/ID register can always be filled, even under stall.
   assign w_accept      = ~r_ifid_valid | ~stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_ST_BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = c_ST_FETCH;
      end else begin
         case (r_state)
            c_ST_BOOT:  w_state_nxt = c_ST_FETCH;
            c_ST_FETCH: if (imem_ack && !w_accept) w_state_nxt = c_ST_HOLD;
            c_ST_HOLD:  if (!stall) w_state_nxt = c_ST_FETCH;
            default:    w_state_nxt = c_ST_BOOT;
         endcase
      end
   end

   always_comb begin
      imem_req   = 1'b0;
      fetch_busy = 1'b0;
      case (r_state)
         c_ST_FETCH: begin
            imem_req   = 1'b1;
            fetch_busy = ~imem_ack;
         end
         c_ST_HOLD: fetch_busy = 1'b1;
         default: begin
            imem_req   = 1'b0;
            fetch_busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc            <= c_RESET_PC;
         r_ifid_valid    <= 1'b0;
         r_ifid_instr    <= '0;
         r_ifid_pc_plus4 <= '0;
         r_skid_instr    <= '0;
         r_skid_pc_plus4 <= '0;
      end else if (flush) begin
         // A word acked in the flush cycle belongs to the wrong path and is dropped.
         r_pc            <= branch_target;
         r_ifid_valid    <= 1'b0;
         r_skid_instr    <= '0;
         r_skid_pc_plus4 <= '0;
      end else begin
         case (r_state)
            c_ST_FETCH: begin
               if (imem_ack) begin
                  r_pc <= w_pc_next_seq;
                  if (w_accept) begin
                     r_ifid_valid    <= 1'b1;
                     r_ifid_instr    <= imem_rdata;
                     r_ifid_pc_plus4 <= w_pc_next_seq;
                  end else begin
                     r_skid_instr    <= imem_rdata;
                     r_skid_pc_plus4 <= w_pc_next_seq;
                  end
               end else if (!stall) begin
                  r_ifid_valid <= 1'b0;
               end
            end
            c_ST_HOLD: begin
               if (!stall) begin
                  r_ifid_valid    <= 1'b1;
                  r_ifid_instr    <= r_skid_instr;
                  r_ifid_pc_plus4 <= r_skid_pc_plus4;
                  r_skid_instr    <= '0;
                  r_skid_pc_plus4 <= '0;
               end
            end
            default: begin
               r_pc <= r_pc;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_cnt;
   logic        w_perf_inc;

   assign w_perf_inc = (r_state == c_ST_HOLD) || ((r_state == c_ST_FETCH) && !imem_ack);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_cnt <= '0;
      end else if (w_perf_inc && (r_perf_cnt != 32'hFFFF_FFFF)) begin
         r_perf_cnt <= r_perf_cnt + 32'd1;
      end
   end

   assign perf_stall_cycles = r_perf_cnt;
`endif

   assign imem_addr     = r_pc;
   assign ifid_valid    = r_ifid_valid;
   assign ifid_instr    = r_ifid_instr;
   assign ifid_pc_plus4 = r_ifid_pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_if_id_fetch_stage.sv
//============================================================================
// Module      : tb_if_id_fetch_stage
// Description : Directed, table-driven bench for if_id_fetch_stage.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_if_id_fetch_stage;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        flush;
   logic [31:0] branch_target;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        fetch_busy;

   int total;
   int bad;

   if_id_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .flush         (flush),
      .branch_target (branch_target),
      .ifid_valid    (ifid_valid),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus4 (ifid_pc_plus4),
      .fetch_busy    (fetch_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pre-edge fields check combinational outputs; post-edge fields the IF/ID register.
   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        stall;
      logic        flush;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_busy;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
   } vec_t;

   localparam int NV = 19;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      //          ack rdata         stl flu tgt            req addr          busy val instr         pc4
      vec[0]  = '{0, 32'h0,         0,  0,  32'h0,         0,  32'h0,        0,   0,  32'h0,        32'h0};
      vec[1]  = '{1, 32'hA000_0000, 0,  0,  32'h0,         1,  32'h0,        0,   1,  32'hA000_0000, 32'h4};
      vec[2]  = '{1, 32'hA000_0004, 0,  0,  32'h0,         1,  32'h4,        0,   1,  32'hA000_0004, 32'h8};
      vec[3]  = '{1, 32'hA000_0008, 1,  0,  32'h0,         1,  32'h8,        0,   1,  32'hA000_0004, 32'h8};
      vec[4]  = '{0, 32'h0,         1,  0,  32'h0,         0,  32'hC,        1,   1,  32'hA000_0004, 32'h8};
      vec[5]  = '{0, 32'h0,         1,  0,  32'h0,         0,  32'hC,        1,   1,  32'hA000_0004, 32'h8};
      vec[6]  = '{0, 32'h0,         0,  0,  32'h0,         0,  32'hC,        1,   1,  32'hA000_0008, 32'hC};
      vec[7]  = '{0, 32'h0,         0,  0,  32'h0,         1,  32'hC,        1,   0,  32'hA000_0008, 32'hC};
      vec[8]  = '{0, 32'h0,         0,  0,  32'h0,         1,  32'hC,        1,   0,  32'hA000_0008, 32'hC};
      vec[9]  = '{1, 32'hA000_000C, 0,  0,  32'h0,         1,  32'hC,        0,   1,  32'hA000_000C, 32'h10};
      vec[10] = '{1, 32'hDEAD_BEEF, 1,  1,  32'h100,       1,  32'h10,       0,   0,  32'hA000_000C, 32'h10};
      vec[11] = '{0, 32'h0,         1,  0,  32'h0,         1,  32'h100,      1,   0,  32'hA000_000C, 32'h10};
      vec[12] = '{1, 32'hB000_0100, 1,  0,  32'h0,         1,  32'h100,      0,   1,  32'hB000_0100, 32'h104};
      vec[13] = '{0, 32'h0,         0,  1,  32'hFFFF_FFFC, 1,  32'h104,      1,   0,  32'hB000_0100, 32'h104};
      vec[14] = '{1, 32'hC000_FFFC, 0,  0,  32'h0,         1,  32'hFFFF_FFFC, 0,  1,  32'hC000_FFFC, 32'h0};
      vec[15] = '{1, 32'hC000_0000, 1,  0,  32'h0,         1,  32'h0,        0,   1,  32'hC000_FFFC, 32'h0};
      vec[16] = '{0, 32'h0,         1,  0,  32'h0,         0,  32'h4,        1,   1,  32'hC000_FFFC, 32'h0};
      vec[17] = '{0, 32'h0,         1,  1,  32'h200,       0,  32'h4,        1,   0,  32'hC000_FFFC, 32'h0};
      vec[18] = '{0, 32'h0,         0,  0,  32'h0,         1,  32'h200,      1,   0,  32'hC000_FFFC, 32'h0};

      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0; flush = 1'b0; branch_target = '0;
      repeat (2) @(negedge clk);
      chk("reset imem_req", {31'b0, imem_req}, 32'h0);
      chk("reset imem_addr", imem_addr, 32'h0);
      chk("reset ifid_valid", {31'b0, ifid_valid}, 32'h0);
      chk("reset ifid_instr", ifid_instr, 32'h0);
      chk("reset ifid_pc_plus4", ifid_pc_plus4, 32'h0);
      chk("reset fetch_busy", {31'b0, fetch_busy}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         imem_ack = vec[i].ack; imem_rdata = vec[i].rdata; stall = vec[i].stall;
         flush = vec[i].flush; branch_target = vec[i].tgt;
         #1;
         chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vec[i].e_req});
         chk($sformatf("v%0d imem_addr", i), imem_addr, vec[i].e_addr);
         chk($sformatf("v%0d fetch_busy", i), {31'b0, fetch_busy}, {31'b0, vec[i].e_busy});
         @(posedge clk); #1;
         chk($sformatf("v%0d ifid_valid", i), {31'b0, ifid_valid}, {31'b0, vec[i].e_valid});
         chk($sformatf("v%0d ifid_instr", i), ifid_instr, vec[i].e_instr);
         chk($sformatf("v%0d ifid_pc_plus4", i), ifid_pc_plus4, vec[i].e_pc4);
         @(negedge clk);
      end

      // Build a HOLD again, then hit it with an asynchronous reset mid-cycle.
      imem_ack = 1'b1; imem_rdata = 32'hE000_0200; stall = 1'b0; flush = 1'b0;
      @(negedge clk);
      imem_rdata = 32'hE000_0204; stall = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      chk("hold before rst imem_req", {31'b0, imem_req}, 32'h0);
      chk("hold before rst imem_addr", imem_addr, 32'h208);
      #1 rst = 1'b1;
      #1;
      chk("async rst imem_req", {31'b0, imem_req}, 32'h0);
      chk("async rst ifid_valid", {31'b0, ifid_valid}, 32'h0);
      chk("async rst imem_addr", imem_addr, 32'h0);
      chk("async rst fetch_busy", {31'b0, fetch_busy}, 32'h0);
      @(negedge clk);
      rst = 1'b0; stall = 1'b0;
      #1;
      chk("post rst boot imem_req", {31'b0, imem_req}, 32'h0);
      @(negedge clk);
      #1;
      chk("post rst fetch imem_req", {31'b0, imem_req}, 32'h1);
      chk("post rst fetch imem_addr", imem_addr, 32'h0);
      chk("post rst skid empty", {31'b0, ifid_valid}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
